// File: rtl/fifo_mwmr_pkg.sv
// Shared definitions for the dec->ix multi-lane bundle queue: default lane count,
// default bundle width and small helpers for counter widths and modulo-DEPTH pointer arithmetic.
package fifo_mwmr_pkg;

  localparam int FIFO_MWMR_LANES = 2;
  localparam int BUNDLE_WIDTH    = 248;

  // Bits needed to hold a count of 0..lanes.
  function automatic int count_bits(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  // ptr and n are both below depth, so a single conditional subtract wraps correctly.
  function automatic int wrap_add(input int ptr, input int n, input int depth);
    int sum;
    sum = ptr + n;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

endpackage

// File: rtl/fifo_mwmr_prefix.sv
// Leading-ones counter: number of consecutive set bits starting from bit 0.
// Used for write admission (n_w) and in-order retirement (n_r).
module fifo_mwmr_prefix
  import fifo_mwmr_pkg::*;
#(
  parameter  int LANES = 2,
  localparam int CW    = count_bits(LANES)
) (
  input  logic [LANES-1:0] bits,
  output logic [CW-1:0]    count
);

  logic run;

  // NOTE: combinational blocks use blocking '=' so later statements see the
  // updated run/count; every variable is given a default first so no latch is inferred.
  always_comb begin
    run   = 1'b1;
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      run = run & bits[i];
      if (run) count = count + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_mwmr.sv
// Multi-lane in-order queue between dec and ix: LANES writes and LANES reads per cycle, any DEPTH.
// Define FIFO_MWMR_BYPASS_EN to forward incoming writes straight to the read lanes when level < LANES.
module fifo_mwmr
  import fifo_mwmr_pkg::*;
#(
  parameter int WIDTH     = BUNDLE_WIDTH,
  parameter int LANES     = FIFO_MWMR_LANES,
  parameter int DEPTH     = 6,
  parameter int ABITS     = 3,
  parameter int AF_THRESH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [LANES*WIDTH-1:0] a_data,
  input  logic [LANES-1:0]       a_valid,
  output logic                   a_ready,
  output logic [LANES*WIDTH-1:0] b_data,
  output logic [LANES-1:0]       b_valid,
  input  logic [LANES-1:0]       b_ready,
  output logic [ABITS:0]         level,
  output logic                   almost_full
);

  localparam int CW = count_bits(LANES);
  localparam int LW = ABITS + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ABITS-1:0] rd_ptr;
  logic [ABITS-1:0] wr_ptr;
  logic [ABITS-1:0] rd_slot [LANES];
  logic [ABITS-1:0] wr_slot [LANES];
  logic [CW-1:0]    n_w_raw;
  logic [CW-1:0]    n_w;
  logic [CW-1:0]    n_r;
  logic [LANES-1:0] pop_req;
  logic [LANES-1:0] store_en;

  // Admission looks only at registered level: same-cycle pops never grant credit.
  assign a_ready     = (level <= LW'(DEPTH - LANES));
  assign almost_full = (level >= LW'(AF_THRESH));

  fifo_mwmr_prefix #(.LANES(LANES)) u_wr_prefix (
    .bits  (a_valid),
    .count (n_w_raw)
  );

  assign n_w     = a_ready ? n_w_raw : '0;
  assign pop_req = b_valid & b_ready;

  fifo_mwmr_prefix #(.LANES(LANES)) u_rd_prefix (
    .bits  (pop_req),
    .count (n_r)
  );

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rd_slot[i] = ABITS'(wrap_add(int'(rd_ptr), i, DEPTH));
      wr_slot[i] = ABITS'(wrap_add(int'(wr_ptr), i, DEPTH));
    end
  end

  always_comb begin
    b_valid = '0;
    b_data  = '0;
    for (int k = 0; k < LANES; k++) begin
      b_valid[k]               = (k < int'(level));
      b_data[k*WIDTH +: WIDTH] = mem[rd_slot[k]];
`ifdef FIFO_MWMR_BYPASS_EN
      for (int j = 0; j < LANES; j++) begin
        if ((k == int'(level) + j) && (j < int'(n_w))) begin
          b_valid[k]               = 1'b1;
          b_data[k*WIDTH +: WIDTH] = a_data[j*WIDTH +: WIDTH];
        end
      end
`endif
    end
  end

  // Write lane i lands at queue position level+i; it is skipped if already retired by bypass.
  always_comb begin
    store_en = '0;
    for (int i = 0; i < LANES; i++) begin
      store_en[i] = (i < int'(n_w)) && ((int'(level) + i) >= int'(n_r));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      rd_ptr <= ABITS'(wrap_add(int'(rd_ptr), int'(n_r), DEPTH));
      wr_ptr <= ABITS'(wrap_add(int'(wr_ptr), int'(n_w), DEPTH));
      level  <= level + LW'(n_w) - LW'(n_r);
    end
  end

  // NOTE: storage is deliberately left out of reset; b_valid qualifies its contents,
  // and an unreset array maps to plain flops or RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < LANES; i++) begin
        if (store_en[i]) mem[wr_slot[i]] <= a_data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fifo_mwmr.sv
// Directed self-checking bench for fifo_mwmr (WIDTH=8, LANES=2, DEPTH=6, AF_THRESH=4).
// The bypass case is exercised only when FIFO_MWMR_BYPASS_EN is defined.
module tb_fifo_mwmr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] a_data;
  logic [1:0]  a_valid;
  logic        a_ready;
  logic [15:0] b_data;
  logic [1:0]  b_valid;
  logic [1:0]  b_ready;
  logic [3:0]  level;
  logic        almost_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_mwmr #(
    .WIDTH(8), .LANES(2), .DEPTH(6), .ABITS(3), .AF_THRESH(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .a_data      (a_data),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .b_data      (b_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .level       (level),
    .almost_full (almost_full)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write2(input logic [7:0] lane1, input logic [7:0] lane0);
    a_data  = {lane1, lane0};
    a_valid = 2'b11;
    tick();
    a_valid = 2'b00;
  endtask

  logic [15:0] drain_exp [3] = '{16'h1312, 16'h1514, 16'h1716};
  logic [7:0]  exp_next;

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    a_data  = '0;
    a_valid = '0;
    b_ready = '0;
    #12;
    check("rst_level", level, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_af", almost_full, 0);
    rst_n = 1'b1;
    tick();

    // 1: first dual write visible one cycle later
    write2(8'h11, 8'h10);
    check("t1_level", level, 2);
    check("t1_b_valid", b_valid, 2'b11);
    check("t1_b_data", b_data, 16'h1110);

    // 2: fill to DEPTH, held write while full, pop restores a_ready
    write2(8'h13, 8'h12);
    check("t2_level4", level, 4);
    check("t2_af4", almost_full, 1);
    check("t2_ready4", a_ready, 1);
    write2(8'h15, 8'h14);
    check("t2_level6", level, 6);
    check("t2_ready6", a_ready, 0);
    check("t2_af6", almost_full, 1);
    check("t2_bv_full", b_valid, 2'b11);
    a_data  = 16'h1716;
    a_valid = 2'b11;
    tick();
    check("t2_held_level", level, 6);
    check("t2_held_data", b_data, 16'h1110);
    b_ready = 2'b11;
    tick();
    check("t2_pop_level", level, 4);
    check("t2_pop_ready", a_ready, 1);
    check("t2_pop_data", b_data, 16'h1312);
    b_ready = 2'b00;
    tick();
    a_valid = 2'b00;
    check("t2_refill_level", level, 6);
    b_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_drain%0d", i), b_data, drain_exp[i]);
      tick();
    end
    b_ready = 2'b00;
    check("t2_empty", level, 0);

    // 3: streaming through the pointer wrap, 2 in / 2 out per cycle
    exp_next = 8'h20;
    b_ready  = 2'b11;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        a_data  = {8'(8'h21 + 2 * c), 8'(8'h20 + 2 * c)};
        a_valid = 2'b11;
      end else begin
        a_valid = 2'b00;
      end
      #1;
      if (b_valid == 2'b11) begin
        check("t3_pair", b_data, {exp_next + 8'h01, exp_next});
        exp_next = exp_next + 8'h02;
      end
      @(posedge clk);
      #1;
      check("t3_level_bound", 32'(level <= 4'd6), 1);
    end
    b_ready = 2'b00;
    check("t3_count", exp_next, 8'h2C);
    check("t3_empty", level, 0);

    // 4: gapped ready retires nothing; lane0-only retires one
    write2(8'h41, 8'h40);
    b_ready = 2'b10;
    tick();
    check("t4_gap_level", level, 2);
    check("t4_gap_data", b_data, 16'h4140);
    b_ready = 2'b01;
    tick();
    check("t4_one_level", level, 1);
    check("t4_one_valid", b_valid, 2'b01);
    check("t4_one_data", b_data[7:0], 8'h41);
    tick();
    b_ready = 2'b00;
    check("t4_empty", level, 0);

    // 5: flush wins over same-cycle writes
    write2(8'h51, 8'h50);
    write2(8'h53, 8'h52);
    check("t5_level4", level, 4);
    a_data  = 16'h5554;
    a_valid = 2'b11;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    a_valid = 2'b00;
    check("t5_level", level, 0);
    check("t5_b_valid", b_valid, 0);
    check("t5_a_ready", a_ready, 1);
    check("t5_af", almost_full, 0);
    write2(8'h57, 8'h56);
    check("t5_after", b_data, 16'h5756);
    check("t5_after_level", level, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;

`ifdef FIFO_MWMR_BYPASS_EN
    // 6: empty-queue bypass, lane0 retired in the same cycle
    a_data  = 16'h3130;
    a_valid = 2'b11;
    b_ready = 2'b01;
    #1;
    check("t6_bv", b_valid, 2'b11);
    check("t6_bdata", b_data, 16'h3130);
    @(posedge clk);
    #1;
    a_valid = 2'b00;
    b_ready = 2'b00;
    check("t6_level", level, 1);
    check("t6_lane0", b_data[7:0], 8'h31);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_mwmr.md
Name: fifo_mwmr

Overview:
- Parametrised multi-lane in-order queue with LANES write ports and LANES read ports. Generalises the fixed 2-write/2-read decoded-instruction queue.
- Sits between dec and ix. Absorbs up to LANES decoded bundles per cycle and presents the oldest LANES entries to issue.
- Supports arbitrary (non-power-of-2) DEPTH, a synchronous flush, occupancy reporting, and optional empty-queue bypass.

Parameters:
- WIDTH, 248: bits per entry.
- LANES, 2: ports per side; 1..4.
- DEPTH, 6: entries. Must satisfy DEPTH >= LANES; need not be a power of 2.
- ABITS, 3: pointer width, ceil(log2(DEPTH)).
- AF_THRESH, 4: level at or above which almost_full asserts.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipe flush; empties the queue.
- a_data  in  LANES*WIDTH  write data; lane i at [i*WIDTH +: WIDTH]; lane 0 is oldest.
- a_valid  in  LANES  per-lane write valid.
- a_ready  out  1  queue accepts writes this cycle.
- b_data  out  LANES*WIDTH  read data; lane 0 is the oldest entry.
- b_valid  out  LANES  per-lane read valid.
- b_ready  in  LANES  per-lane consumer ready.
- level  out  ABITS+1  current occupancy, 0..DEPTH.
- almost_full  out  1  level >= AF_THRESH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Clears rd_ptr, wr_ptr and level to 0.
  - Outputs: b_valid=0, a_ready=1, almost_full=0 (AF_THRESH>0).
  - Storage is not cleared; b_data is don't-care while the corresponding b_valid=0.
- Pointers:
  - wrap modulo DEPTH: next = ptr+n, minus DEPTH if >= DEPTH.
  - Slot for lane i = (ptr+i) mod DEPTH.
- Write rules:
  - a_valid is treated as a prefix: number of writes n_w = count of leading ones from lane 0. Lanes after the first zero are ignored.
  - a_ready = (DEPTH - level) >= LANES, computed from registered level only. Same-cycle pops give no credit; a_ready has no combinational dependence on b_ready.
  - Writes occur only when a_ready=1. With a_ready=0, all a_valid are dropped and the producer must hold them.
- Read rules:
  - b_valid[i] = (level > i).
  - b_data lane i = mem[(rd_ptr+i) mod DEPTH].
  - Pops n_r = count of leading lanes with b_valid&b_ready. A gap stops counting, so in-order retirement is guaranteed.
- Update:
  - level_next = level + n_w - n_r.
  - Simultaneous write and read in one cycle is legal at any level, including level = DEPTH - LANES.
  - Registered outputs derive from level; latency from write to b_valid is 1 cycle.
- Flush:
  - Synchronous. On the edge it clears pointers and level to 0; same-cycle writes and pops are discarded.
  - Flush has priority over everything except reset.
- Boundary cases:
  - Full (level=DEPTH): b_valid all 1 (DEPTH>=LANES); a_ready=0.
  - Empty: b_valid all 0; b_ready is ignored.
  - level between 0 and LANES: only the low lanes are valid.

Optional Feature:
- Macro: FIFO_MWMR_BYPASS_EN.
- Defined: when level < LANES, incoming writes are forwarded combinationally.
  - Effective lane k = stored entry if k < level, else write lane k-level, when that write is valid and a_ready=1.
  - b_valid reflects these merged entries.
  - Popped bypassed entries are never stored.
  - level_next uses the same formula.
  - Adds an a_valid->b_valid combinational path.
- Undefined: no bypass; minimum write-to-read latency 1 cycle.

Decomposition:
- Shared package/defines.vh: lane-count macro, default bundle width (248), bundle field offsets already used by dec/ix.
- Sub-module fifo_mwmr_prefix: LANES-bit leading-ones counter. Instantiated twice, once for n_w and once for n_r.
- Storage is a flat register array inside fifo_mwmr.

Test Plan (WIDTH=8, LANES=2, DEPTH=6, AF_THRESH=4, bypass off unless stated):
1. Reset release, then write {lane1=0x11, lane0=0x10} -> next cycle level=2, b_valid=2'b11, b_data lane0=0x10, lane1=0x11.
2. Fill with 3 dual writes -> level=6, a_ready=0, almost_full=1. A 4th write is held and dropped; after a pop of 2, a_ready=1.
3. Wrap-around: write 0x20..0x2B (12 entries) with 2 pops per cycle, interleaved -> output sequence 0x20..0x2B in order, no loss, level never above 6.
4. Gapped ready: level=2, b_ready=2'b10 -> n_r=0 and level stays 2. b_ready=2'b01 -> n_r=1; next b_data lane0 = old lane1.
5. flush asserted with a_valid=2'b11 and level=4 -> next cycle level=0, b_valid=0, a_ready=1; the flushed-cycle writes are not stored.
6. FIFO_MWMR_BYPASS_EN, empty queue, write {0x31,0x30}, b_ready=2'b01 -> same cycle b_data lane0=0x30, b_valid=2'b11. Next cycle level=1, lane0=0x31.
